load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_aligner.sv | 24 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, FSM states and store-mask helper for the load/store unit
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B:    store_mask = 4'b0001 << off;
         F3_H:    store_mask = 4'b0011 << off;
         default: store_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - shifts the read word to the addressed byte lane and sign/zero-extends it
module load_aligner
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {offset, 3'b000};
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   result = {24'd0, shifted[7:0]};
         F3_HU:   result = {16'd0, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one-outstanding RV32I load/store unit driving a sync-read byte-masked word memory
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic                  mem_read_enable,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   output logic [3:0]            mem_write_mask,
   input  logic [31:0]           mem_read_data
);

   lsu_state_e            state_q, state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  write_q, write_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            off_q, off_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic                  resp_error_q, resp_error_d;
   logic                  mem_re_q, mem_re_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_mask_q, mem_mask_d;
   logic                  req_err;
   logic [31:0]           load_result;

   load_aligner u_aligner (
      .word   (mem_read_data),
      .offset (off_q),
      .funct3 (funct3_q),
      .result (load_result)
   );

   always_comb begin
      req_err = |(req_addr >> (ADDR_WIDTH + 2));
      case (req_funct3)
         F3_B:         ;
         F3_H:         req_err = req_err | req_addr[0];
         F3_W:         req_err = req_err | (req_addr[1:0] != 2'b00);
         F3_BU:        req_err = req_err | req_write;
         F3_HU:        req_err = req_err | req_write | req_addr[0];
         default:      req_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = 32'd0;
      mem_mask_d   = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               if (req_err) begin
                  state_d      = ST_RESP;
                  resp_rdata_d = 32'd0;
                  resp_error_d = 1'b1;
               end else begin
                  state_d    = ST_ISSUE;
                  write_d    = req_write;
                  funct3_d   = req_funct3;
                  off_d      = req_addr[1:0];
                  mem_addr_d = req_addr[ADDR_WIDTH+1:2];
                  if (req_write) begin
                     mem_we_d   = 1'b1;
                     mem_mask_d = store_mask(req_funct3, req_addr[1:0]);
                     case (req_funct3)
                        F3_B:    mem_wdata_d = {4{req_wdata[7:0]}};
                        F3_H:    mem_wdata_d = {2{req_wdata[15:0]}};
                        default: mem_wdata_d = req_wdata;
                     endcase
                  end else begin
                     mem_re_d = 1'b1;
                  end
               end
            end
         end
         ST_ISSUE: begin
            if (write_q) begin
               state_d      = ST_RESP;
               resp_rdata_d = 32'd0;
               resp_error_d = 1'b0;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            state_d      = ST_RESP;
            resp_rdata_d = load_result;
            resp_error_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      resp_valid_d = (state_d == ST_RESP);
      req_ready_d  = (state_d == ST_IDLE);
   end

   // Every output is a flop so reset clears them all without a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b0;
         write_q      <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_error_q <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         mem_mask_q   <= 4'b0000;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         write_q      <= write_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_mask_q   <= mem_mask_d;
      end
   end

   assign req_ready        = req_ready_q;
   assign resp_valid       = resp_valid_q;
   assign resp_rdata       = resp_rdata_q;
   assign resp_error       = resp_error_q;
   assign mem_read_enable  = mem_re_q;
   assign mem_write_enable = mem_we_q;
   assign mem_address      = mem_addr_q;
   assign mem_write_data   = mem_wdata_q;
   assign mem_write_mask   = mem_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a sync-read word memory
module tb_load_store_unit;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [2:0]    req_funct3 = 3'd0;
   logic [31:0]   req_addr = 32'd0;
   logic [31:0]   req_wdata = 32'd0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_error;
   logic          mem_read_enable;
   logic          mem_write_enable;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_write_data;
   logic [3:0]    mem_write_mask;
   logic [31:0]   mem_read_data;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          mem_init = 1'b0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            en_count = 0;
   int            resp_count = 0;
   logic [3:0]    wr_mask;
   logic [31:0]   wr_data;
   logic [AW-1:0] wr_addr;

   load_store_unit #(.ADDR_WIDTH(AW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_error       (resp_error),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_mask   (mem_write_mask),
      .mem_read_data    (mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge mem_init) begin
      if (mem_init) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'd0;
         mem[0] <= 32'h8899AABB;
         mem[1] <= 32'h11223344;
         mem[2] <= 32'h55667788;
      end else begin
         if (mem_read_enable) mem_read_data <= mem[mem_address];
         if (mem_write_enable)
            for (int b = 0; b < 4; b++)
               if (mem_write_mask[b]) mem[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
   end

   always @(negedge clk) begin
      if (mem_read_enable || mem_write_enable) en_count <= en_count + 1;
      if (resp_valid) resp_count <= resp_count + 1;
      if (mem_write_enable) begin
         wr_mask <= mem_write_mask;
         wr_data <= mem_write_data;
         wr_addr <= mem_address;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_en);
      int lat;
      int en0;
      int rc0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      en0 = en_count;
      rc0 = resp_count;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " rdata"}, resp_rdata, exp_rd);
      chk({tag, " error"}, {31'd0, resp_error}, {31'd0, exp_err});
      @(posedge clk); #1;
      chk({tag, " valid_drop"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, " rdata_hold"}, resp_rdata, exp_rd);
      @(negedge clk);
      chk({tag, " mem_enables"}, en_count - en0, exp_en);
      chk({tag, " resp_pulses"}, resp_count - rc0, 32'd1);
   endtask

   initial begin
      mem_init = 1'b1;
      #2 mem_init = 1'b0;
      #1;
      chk("rst ready", {31'd0, req_ready}, 32'd0);
      chk("rst valid", {31'd0, resp_valid}, 32'd0);
      chk("rst en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
      chk("rst mask", {28'd0, mem_write_mask}, 32'd0);
      chk("rst rdata", resp_rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      #1 chk("post_rst ready_pre_edge", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("post_rst ready", {31'd0, req_ready}, 32'd1);

      do_req("lb_001",  1'b0, 3'b000, 32'h001, 32'd0, 3, 32'hFFFFFFAA, 1'b0, 1);
      do_req("lhu_002", 1'b0, 3'b101, 32'h002, 32'd0, 3, 32'h00008899, 1'b0, 1);
      do_req("lh_002",  1'b0, 3'b001, 32'h002, 32'd0, 3, 32'hFFFF8899, 1'b0, 1);
      do_req("lbu_000", 1'b0, 3'b100, 32'h000, 32'd0, 3, 32'h000000BB, 1'b0, 1);

      do_req("sb_007",  1'b1, 3'b000, 32'h007, 32'h123456EF, 2, 32'd0, 1'b0, 1);
      chk("sb_007 mask", {28'd0, wr_mask}, 32'h8);
      chk("sb_007 wdata", wr_data, 32'hEFEFEFEF);
      chk("sb_007 addr", {22'd0, wr_addr}, 32'd1);
      do_req("lw_004",  1'b0, 3'b010, 32'h004, 32'd0, 3, 32'hEF223344, 1'b0, 1);

      do_req("lw_006_err", 1'b0, 3'b010, 32'h006, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("sh_003_err", 1'b1, 3'b001, 32'h003, 32'hFFFF, 1, 32'd0, 1'b1, 0);
      do_req("range_err",  1'b0, 3'b010, 32'h00001000, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("f3_011_err", 1'b0, 3'b011, 32'h000, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("sbu_err",    1'b1, 3'b100, 32'h000, 32'd0, 1, 32'd0, 1'b1, 0);
      do_req("lw_after_err", 1'b0, 3'b010, 32'h000, 32'd0, 3, 32'h8899AABB, 1'b0, 1);

      // Store interrupted by reset while it sits in ISSUE.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h008; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort we_in_issue", {31'd0, mem_write_enable}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort we_drop", {31'd0, mem_write_enable}, 32'd0);
      chk("abort mask_drop", {28'd0, mem_write_mask}, 32'd0);
      chk("abort ready_low", {31'd0, req_ready}, 32'd0);
      begin
         int rc0;
         rc0 = resp_count;
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk("abort no_resp", resp_count - rc0, 32'd0);
      end
      chk("abort mem_unchanged", mem[2], 32'h55667788);
      reset_n = 1'b1;
      #1 chk("abort ready_pre_edge", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("abort ready_after", {31'd0, req_ready}, 32'd1);

      do_req("sh_00a",  1'b1, 3'b001, 32'h00A, 32'h0000CAFE, 2, 32'd0, 1'b0, 1);
      chk("sh_00a mask", {28'd0, wr_mask}, 32'hC);
      chk("sh_00a wdata", wr_data, 32'hCAFECAFE);
      do_req("lw_008",  1'b0, 3'b010, 32'h008, 32'd0, 3, 32'hCAFE7788, 1'b0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
